// File: rtl/fir_l3_pkg.sv
// Shared definitions for the L=3 FIR capture buffer.
// Holds the beat size, the FSM state encodings and helpers that derive
// the memory depth and the last legal beat start address from the
// address width.
package fir_l3_pkg;

  localparam int L_BEAT = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // Highest address at which a full 3-word beat still fits.
  function automatic int last_beat_addr(input int aw);
    return depth_of(aw) - L_BEAT;
  endfunction

endpackage

// File: rtl/capture_ram_3w1r.sv
// Three-word-write, one-word-registered-read memory.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - async active-low reset (read register only; array is not reset)
//   we       - write enable for all three words
//   wa       - base write address; words land at wa, wa+1, wa+2
//   wd_1..3  - write data for wa, wa+1, wa+2
//   rd_addr  - read address
//   rd_data  - registered read data, 1-cycle latency, read-before-write
module capture_ram_3w1r
  import fir_l3_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd_1,
  input  logic [DATA_WIDTH-1:0] wd_2,
  input  logic [DATA_WIDTH-1:0] wd_3,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [depth_of(ADDR_WIDTH)];
  logic [ADDR_WIDTH-1:0] wa_1;
  logic [ADDR_WIDTH-1:0] wa_2;

  assign wa_1 = wa + ADDR_WIDTH'(1);
  assign wa_2 = wa + ADDR_WIDTH'(2);

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa]   <= wd_1;
      mem[wa_1] <= wd_2;
      mem[wa_2] <= wd_3;
    end
  end

  // Non-blocking read of the array yields the pre-write value on a
  // same-cycle collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fir_l3_capture_buffer.sv
// Capture buffer for the L=3 reduced-parallel FIR bench.
// Each valid cycle during capture stores three consecutive filter output
// samples; the frame is then held for single-word readback.
// Ports:
//   clk, rst_n          - clock, async active-low reset
//   start               - pulse: clear pointer/flags and begin capture
//   stop                - pulse: end capture early
//   in_valid, in_data_* - three samples for wr_ptr, wr_ptr+1, wr_ptr+2
//   rd_addr, rd_data    - readback port, 1-cycle registered latency
//   busy / done         - state is CAPTURE / FULL
//   count               - words captured so far
//   overflow            - sticky: beat offered after capture ended
module fir_l3_capture_buffer
  import fir_l3_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int L          = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data_1,
  input  logic [DATA_WIDTH-1:0] in_data_2,
  input  logic [DATA_WIDTH-1:0] in_data_3,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  if (L != L_BEAT) begin : g_bad_l
    $error("fir_l3_capture_buffer: L must be 3");
  end

  localparam logic [ADDR_WIDTH:0] LAST_BEAT = (ADDR_WIDTH+1)'(last_beat_addr(ADDR_WIDTH));

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH:0]   next_ptr;
  logic                  we;

  // One bit wider than the address so the end-of-buffer test cannot wrap.
  assign next_ptr = {1'b0, wr_ptr} + (ADDR_WIDTH+1)'(L);

  // A beat coinciding with start is dropped.
  assign we = (state == ST_CAPTURE) && in_valid && !start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      state    <= ST_CAPTURE;
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_CAPTURE: begin
          if (in_valid) wr_ptr <= next_ptr[ADDR_WIDTH-1:0];
          if (stop || (in_valid && next_ptr > LAST_BEAT)) state <= ST_FULL;
        end
        ST_FULL: begin
          if (in_valid) overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Every beat is exactly L words, so the word count equals the pointer.
  assign count = {1'b0, wr_ptr};
  assign busy  = (state == ST_CAPTURE);
  assign done  = (state == ST_FULL);

  capture_ram_3w1r #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .wa      (wr_ptr),
    .wd_1    (in_data_1),
    .wd_2    (in_data_2),
    .wd_3    (in_data_3),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_fir_l3_capture_buffer.sv
module tb_fir_l3_capture_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] d1 = '0, d2 = '0, d3 = '0;
  logic [8:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        busy, done, overflow;
  logic [9:0]  count;

  int total = 0;
  int bad = 0;

  fir_l3_capture_buffer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .in_valid(in_valid), .in_data_1(d1), .in_data_2(d2), .in_data_3(d3),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: a word list plus a capture phase.
  logic [15:0] mm [512];
  bit          known [512];
  int          m_words = 0;     // words captured
  bit          m_cap = 0;
  bit          m_full = 0;
  bit          m_ovf = 0;
  logic [15:0] m_rd = '0;
  bit          m_rd_known = 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cap = 0; m_full = 0; m_words = 0; m_ovf = 0;
      m_rd = '0; m_rd_known = 1;
    end else begin
      m_rd = mm[rd_addr];
      m_rd_known = known[rd_addr];
      if (start) begin
        m_cap = 1; m_full = 0; m_words = 0; m_ovf = 0;
      end else if (m_cap) begin
        if (in_valid) begin
          mm[m_words] = d1;   known[m_words] = 1;
          mm[m_words+1] = d2; known[m_words+1] = 1;
          mm[m_words+2] = d3; known[m_words+2] = 1;
          m_words += 3;
        end
        // 170 beats of 3 words fill 510 of the 512 words.
        if (stop || m_words == 510) begin
          m_cap = 0; m_full = 1;
        end
      end else if (m_full && in_valid) begin
        m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_busy", int'(busy), int'(m_cap));
      chk("m_done", int'(done), int'(m_full));
      chk("m_count", int'(count), m_words);
      chk("m_overflow", int'(overflow), int'(m_ovf));
      if (m_rd_known) chk("m_rd_data", int'(rd_data), int'(m_rd));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input int a, input int b, input int c);
    in_valid = 1'b1;
    d1 = 16'(a); d2 = 16'(b); d3 = 16'(c);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic read_chk(input string name, input int addr, input int exp);
    rd_addr = 9'(addr);
    @(negedge clk);
    chk(name, int'(rd_data), exp);
  endtask

  int pre510;

  initial begin
    for (int i = 0; i < 512; i++) begin mm[i] = '0; known[i] = 0; end
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // in_valid in IDLE is ignored and not flagged
    beat(7, 7, 7);
    chk("idle_ignore_count", int'(count), 0);
    chk("idle_ignore_ovf", int'(overflow), 0);

    // Four beats
    pulse_start();
    for (int k = 0; k < 4; k++) beat(3*k+1, 3*k+2, 3*k+3);
    chk("t1_count", int'(count), 12);
    chk("t1_busy", int'(busy), 1);
    for (int i = 0; i < 12; i++) read_chk("t1_read", i, i + 1);

    // Full buffer
    pulse_start();
    for (int k = 0; k < 170; k++) begin
      beat(3*k+1, 3*k+2, 3*k+3);
      if (k == 168) chk("t2_busy_before_last", int'(busy), 1);
    end
    chk("t2_done", int'(done), 1);
    chk("t2_count", int'(count), 510);
    chk("t2_busy", int'(busy), 0);
    rd_addr = 9'd510;
    @(negedge clk);
    pre510 = int'(rd_data);
    beat(16'hBEEF, 16'hBEEF, 16'hBEEF);
    chk("t2_overflow", int'(overflow), 1);
    chk("t2_count_hold", int'(count), 510);
    @(negedge clk);
    chk("t2_mem510_unwritten", int'(rd_data), pre510);
    read_chk("t2_mem509", 509, 510);

    // start with coincident beat: dropped
    start = 1'b1; in_valid = 1'b1; d1 = 16'hAAAA; d2 = 16'hAAAA; d3 = 16'hAAAA;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    chk("t3_count", int'(count), 0);
    chk("t3_overflow", int'(overflow), 0);
    chk("t3_done", int'(done), 0);
    beat(16'h11, 16'h22, 16'h33);
    read_chk("t3_addr0", 0, 16'h11);
    read_chk("t3_addr2", 2, 16'h33);

    // stop with coincident sixth beat
    pulse_start();
    for (int k = 0; k < 5; k++) beat(200+3*k, 201+3*k, 202+3*k);
    stop = 1'b1;
    beat(215, 216, 217);
    stop = 1'b0;
    chk("t4_count", int'(count), 18);
    chk("t4_done", int'(done), 1);
    read_chk("t4_addr17", 17, 217);
    beat(1, 1, 1);
    chk("t4_overflow", int'(overflow), 1);
    pulse_start();
    chk("t4_clr_overflow", int'(overflow), 0);
    chk("t4_clr_done", int'(done), 0);
    chk("t4_clr_count", int'(count), 0);

    // async reset mid-capture
    for (int k = 0; k < 3; k++) beat(100+3*k, 101+3*k, 102+3*k);
    rd_addr = 9'd4;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", int'(busy), 0);
    chk("t5_count", int'(count), 0);
    chk("t5_rd_data", int'(rd_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) read_chk("t5_keep", i, 100 + i);

    // read-before-write
    pulse_start();
    rd_addr = 9'd3;
    beat(1, 2, 3);
    chk("t6_pre", int'(rd_data), 103);
    beat(16'h55, 16'h66, 16'h77);
    chk("t6_old", int'(rd_data), 103);
    @(negedge clk);
    chk("t6_new", int'(rd_data), 16'h55);

    // randomized phase
    for (int c = 0; c < 4000; c++) begin
      start    = ($urandom_range(0, 399) == 0);
      stop     = ($urandom_range(0, 299) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      d1 = 16'($urandom); d2 = 16'($urandom); d3 = 16'($urandom);
      rd_addr = 9'($urandom);
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_l3_capture_buffer.md
Name: fir_l3_capture_buffer

Overview:
- Sink-side counterpart to the 3-sample parallel stimulus ROM for the L=3 reduced-parallel FIR bench.
- Accepts three consecutive output samples per valid cycle from the filter.
- Writes them into a 2**ADDR_WIDTH-word memory at addr, addr+1 and addr+2.
- Holds the captured frame for single-word readback by the checker and the dump logic.

Parameters:
- ADDR_WIDTH, 9, memory address width; DEPTH = 2**ADDR_WIDTH = 512 words.
- DATA_WIDTH, 16, sample width.
- L, 3, samples per write beat; fixed at 3 (elaboration error otherwise).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: clear pointer and flags, begin capture.
- stop  input  1  one-cycle pulse: end capture early.
- in_valid  input  1  in_data_1..3 valid this cycle.
- in_data_1  input  DATA_WIDTH  sample n, written at wr_ptr.
- in_data_2  input  DATA_WIDTH  sample n+1, written at wr_ptr+1.
- in_data_3  input  DATA_WIDTH  sample n+2, written at wr_ptr+2.
- rd_addr  input  ADDR_WIDTH  readback address.
- rd_data  output  DATA_WIDTH  registered readback data.
- busy  output  1  high in CAPTURE.
- done  output  1  high in FULL.
- count  output  ADDR_WIDTH+1  number of words captured.
- overflow  output  1  sticky: in_valid arrived while not capturing after a start.

Behaviour:
- Reset (async assert, sync release): state IDLE, wr_ptr=0, count=0, busy=0, done=0, overflow=0, rd_data=0. Memory contents are not reset.
- States:
  - IDLE: start -> CAPTURE. in_valid is ignored; no overflow is flagged before the first start.
  - CAPTURE: each in_valid cycle writes 3 words, then wr_ptr += 3 and count += 3.
    - If the new wr_ptr > DEPTH-3 (wr_ptr = 510 for the default), go to FULL.
    - stop -> FULL. An in_valid in the same cycle as stop is still written.
  - FULL: in_valid sets overflow and performs no write. start -> CAPTURE.
- Capacity: max 170 beats = 510 words. Words 510 and 511 are never written. No partial beats.
- start, any state: in that cycle wr_ptr=0, count=0, overflow=0, done=0, next state CAPTURE. A coincident in_valid is dropped and is not flagged. start has priority over stop and in_valid.
- Write timing: memory updated at the clock edge of the in_valid cycle. count and wr_ptr are visible the next cycle.
- busy and done are registered state decodes. done asserts the cycle after the final beat or stop.
- Readback: rd_data <= mem[rd_addr] every cycle, 1-cycle latency, independent of state.
  - Same-cycle read/write of one address returns old data (read-before-write).
- Address arithmetic is ADDR_WIDTH wide. No wrap occurs because the FULL transition precedes it.
- Asserting rst_n low mid-capture aborts immediately to IDLE. Captured words remain in memory but count reads 0.

Decomposition:
- Package fir_l3_pkg: L=3, state enum {IDLE, CAPTURE, FULL}, DEPTH and last-beat-address constants derived from ADDR_WIDTH.
- Sub-module capture_ram_3w1r: 3-port-write, 1-port-registered-read memory.
  - Write ports at wa, wa+1, wa+2 under a single we.
  - Registered read port.
- The top holds the FSM, pointer and flags.

Test Plan:
- Reset, start, then 4 beats of (1,2,3),(4,5,6),(7,8,9),(10,11,12) -> count=12, busy=1; reading addrs 0..11 returns 1..12 one cycle after each rd_addr.
- Start, then 170 consecutive beats of an incrementing pattern -> done=1 the cycle after beat 170, count=510; a 171st beat sets overflow=1 and leaves mem[510] unwritten.
- start and in_valid in the same cycle, with data 0xAAAA -> beat dropped, count=0, overflow=0; the next beat lands at addr 0.
- 5 beats, then stop together with a 6th beat -> FULL, count=18, done=1; a later in_valid sets overflow. start then clears overflow, done and count.
- rst_n low after 3 beats, mid-capture -> busy=0, count=0, rd_data=0 immediately. After release, reading addr 0..8 still returns the captured data.
- rd_addr=3 during the beat writing 3..5 -> rd_data shows old mem[3]; the next cycle shows new mem[3].
